// File: rtl/mem_copy_if.sv
// mem_copy_if: command/status and data-memory port bundle for mem_copy_engine.
//
// Signals (master = the copy engine, slave = command issuer plus memory):
//   start, src_addr, dst_addr, length, fill, fill_data, abort   command inputs to the engine
//   busy, done                                                  engine status
//   memoryRead, memoryWrite, sb, address, dataWrite             memory request, engine-driven
//   dataRead                                                    {mem[address+1], mem[address]}
interface mem_copy_if #(
  parameter int unsigned LEN_W = 16
);
  logic             start;
  logic [15:0]      src_addr;
  logic [15:0]      dst_addr;
  logic [LEN_W-1:0] length;
  logic             fill;
  logic [7:0]       fill_data;
  logic             abort;
  logic             busy;
  logic             done;
  logic             memoryRead;
  logic             memoryWrite;
  logic             sb;
  logic [15:0]      address;
  logic [15:0]      dataWrite;
  logic [15:0]      dataRead;

  modport master (
    input  start, src_addr, dst_addr, length, fill, fill_data, abort, dataRead,
    output busy, done, memoryRead, memoryWrite, sb, address, dataWrite
  );

  modport slave (
    output start, src_addr, dst_addr, length, fill, fill_data, abort, dataRead,
    input  busy, done, memoryRead, memoryWrite, sb, address, dataWrite
  );
endinterface

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: block copy / fill initiator on the data-memory port.
//
// A start command latches source, destination and byte length, then the engine moves the
// block as a mix of 16-bit word and 8-bit byte steps (byte steps at the tail and wherever a
// word access would straddle 0xFFFF). Copy uses an RD cycle then a WR cycle per step; fill
// writes only. The engine owns the memory port while busy is high.
//
// Ports:
//   clk_i    clock, all state changes on the rising edge
//   reset_i  synchronous active-high reset
//   bus      mem_copy_if.master: command/status plus memory request signals
//
// Build option: define MEM_COPY_FILL_EN to honour the fill / fill_data command fields.
// Without it those fields are ignored and every transfer is a copy.
module mem_copy_engine #(
  parameter int unsigned LEN_W = 16
) (
  input  logic      clk_i,
  input  logic      reset_i,
  mem_copy_if.master bus
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e           state_q, state_d;
  logic [15:0]      cur_src_q, cur_src_d;
  logic [15:0]      cur_dst_q, cur_dst_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [15:0]      rd_buf_q, rd_buf_d;
  logic             step_byte_q, step_byte_d;

  logic             fill_cmd;   // fill request of the command being accepted
  logic             fill_mode;  // fill selection of the transfer in progress

  logic [1:0]       step_amt;
  logic [15:0]      src_next;
  logic [15:0]      dst_next;
  logic [LEN_W-1:0] rem_next;

  // A word step is used only when two bytes remain and neither access would wrap past 0xFFFF.
  // The source address is irrelevant in fill mode.
  function automatic logic byte_step(input logic [LEN_W-1:0] rem,
                                     input logic [15:0]      src,
                                     input logic [15:0]      dst,
                                     input logic             fill_sel);
    logic word_ok;
    word_ok = (rem >= LEN_W'(2)) && (dst != 16'hFFFF) && (fill_sel || (src != 16'hFFFF));
    return !word_ok;
  endfunction

`ifdef MEM_COPY_FILL_EN
  logic       fill_q, fill_d;
  logic [7:0] fill_data_q, fill_data_d;

  assign fill_cmd  = bus.fill;
  assign fill_mode = fill_q;

  always_comb begin
    fill_d      = fill_q;
    fill_data_d = fill_data_q;
    if ((state_q == StIdle) && bus.start && (bus.length != '0)) begin
      fill_d      = bus.fill;
      fill_data_d = bus.fill_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fill_q      <= 1'b0;
      fill_data_q <= 8'h00;
    end else begin
      fill_q      <= fill_d;
      fill_data_q <= fill_data_d;
    end
  end
`else
  assign fill_cmd  = 1'b0;
  assign fill_mode = 1'b0;

  logic unused_fill;
  assign unused_fill = ^{bus.fill, bus.fill_data};
`endif

  assign step_amt = step_byte_q ? 2'd1 : 2'd2;
  assign src_next = cur_src_q + {14'd0, step_amt};
  assign dst_next = cur_dst_q + {14'd0, step_amt};
  assign rem_next = rem_q - LEN_W'(step_amt);

  // Status decodes straight from the state register.
  assign bus.busy = (state_q == StRd) || (state_q == StWr);
  assign bus.done = (state_q == StDone);

  always_comb begin
    state_d     = state_q;
    cur_src_d   = cur_src_q;
    cur_dst_d   = cur_dst_q;
    rem_d       = rem_q;
    rd_buf_d    = rd_buf_q;
    step_byte_d = step_byte_q;

    bus.memoryRead  = 1'b0;
    bus.memoryWrite = 1'b0;
    bus.sb          = 1'b0;
    bus.address     = 16'h0000;
    bus.dataWrite   = 16'h0000;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.length == '0) begin
            state_d = StDone;
          end else begin
            cur_src_d   = bus.src_addr;
            cur_dst_d   = bus.dst_addr;
            rem_d       = bus.length;
            step_byte_d = byte_step(bus.length, bus.src_addr, bus.dst_addr, fill_cmd);
            state_d     = fill_cmd ? StWr : StRd;
          end
        end
      end

      StRd: begin
        bus.memoryRead = 1'b1;
        bus.address    = cur_src_q;
        if (bus.abort) begin
          state_d = StIdle;
        end else begin
          rd_buf_d = bus.dataRead;
          state_d  = StWr;
        end
      end

      StWr: begin
        bus.memoryWrite = 1'b1;
        bus.address     = cur_dst_q;
        bus.sb          = step_byte_q;
        bus.dataWrite   = step_byte_q ? {8'h00, rd_buf_q[7:0]} : rd_buf_q;
`ifdef MEM_COPY_FILL_EN
        if (fill_mode) begin
          bus.dataWrite = step_byte_q ? {8'h00, fill_data_q} : {fill_data_q, fill_data_q};
        end
`endif
        // On abort the write above still commits, but no counter moves.
        if (bus.abort) begin
          state_d = StIdle;
        end else begin
          cur_src_d   = src_next;
          cur_dst_d   = dst_next;
          rem_d       = rem_next;
          step_byte_d = byte_step(rem_next, src_next, dst_next, fill_mode);
          if (rem_next == '0) begin
            state_d = StDone;
          end else begin
            state_d = fill_mode ? StWr : StRd;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      cur_src_q   <= 16'h0000;
      cur_dst_q   <= 16'h0000;
      rem_q       <= '0;
      rd_buf_q    <= 16'h0000;
      step_byte_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_src_q   <= cur_src_d;
      cur_dst_q   <= cur_dst_d;
      rem_q       <= rem_d;
      rd_buf_q    <= rd_buf_d;
      step_byte_q <= step_byte_d;
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Testbench for mem_copy_engine: directed sequences plus randomized transfers checked
// against a byte-level reference model of the copy/fill result and its cycle cost.
module tb_mem_copy_engine;

`ifdef MEM_COPY_FILL_EN
  localparam bit FillEn = 1'b1;
`else
  localparam bit FillEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_copy_if #(.LEN_W(16)) ifc ();

  mem_copy_engine #(.LEN_W(16)) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (ifc)
  );

  // Byte-addressed memory answering the engine's requests.
  logic [7:0] mem [0:65535];

  assign ifc.dataRead = {mem[16'(ifc.address + 16'd1)], mem[ifc.address]};

  always @(posedge clk) begin
    if (ifc.memoryWrite === 1'b1) begin
      mem[ifc.address] = ifc.dataWrite[7:0];
      if (ifc.sb === 1'b0) mem[16'(ifc.address + 16'd1)] = ifc.dataWrite[15:8];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] ev(input logic rd, input logic wr, input logic sb,
                                     input logic bsy, input logic dn,
                                     input logic [15:0] a, input logic [15:0] d);
    return {27'd0, rd, wr, sb, bsy, dn, a, d};
  endfunction

  function automatic logic [63:0] obs();
    return {27'd0, ifc.memoryRead, ifc.memoryWrite, ifc.sb, ifc.busy, ifc.done,
            ifc.address, ifc.dataWrite};
  endfunction

  // Presents a command for one edge; returns #1 into cycle 1.
  task automatic issue(input logic [15:0] s, input logic [15:0] d, input logic [15:0] len,
                       input logic f, input logic [7:0] fd);
    ifc.src_addr  = s;
    ifc.dst_addr  = d;
    ifc.length    = len;
    ifc.fill      = f;
    ifc.fill_data = fd;
    ifc.start     = 1'b1;
    tick();
    ifc.start     = 1'b0;
  endtask

  logic [7:0]  snap0, snap1, sentinel, fd;
  logic [15:0] s, d, ss, dd, rd_word;
  int          len, rem, b, steps, exp_done, got_done, rds, wrs;
  bit          f, eff_fill;
  logic [7:0]  exp_bytes [0:63];

  initial begin
    ifc.start = 1'b0; ifc.src_addr = '0; ifc.dst_addr = '0; ifc.length = '0;
    ifc.fill = 1'b0; ifc.fill_data = '0; ifc.abort = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    rst = 1'b1;
    tick();
    chk("reset_outputs", obs(), ev(0, 0, 0, 0, 0, 16'h0000, 16'h0000));
    tick();
    rst = 1'b0;
    tick();
    chk("idle_after_reset", obs(), ev(0, 0, 0, 0, 0, 16'h0000, 16'h0000));

    // Three-byte copy: one word step then one byte step.
    mem[16'h0004] = 8'h12; mem[16'h0005] = 8'h43; mem[16'h0006] = 8'hDE;
    mem[16'h0203] = 8'h5A;
    issue(16'h0004, 16'h0200, 16'd3, 1'b0, 8'h00);
    chk("copy3_c1", obs(), ev(1, 0, 0, 1, 0, 16'h0004, 16'h0000)); tick();
    chk("copy3_c2", obs(), ev(0, 1, 0, 1, 0, 16'h0200, 16'h4312)); tick();
    chk("copy3_c3", obs(), ev(1, 0, 0, 1, 0, 16'h0006, 16'h0000)); tick();
    chk("copy3_c4", obs(), ev(0, 1, 1, 1, 0, 16'h0202, 16'h00DE)); tick();
    chk("copy3_c5", obs(), ev(0, 0, 0, 0, 1, 16'h0000, 16'h0000)); tick();
    chk("copy3_idle", obs(), ev(0, 0, 0, 0, 0, 16'h0000, 16'h0000));
    chk("copy3_mem", {mem[16'h0200], mem[16'h0201], mem[16'h0202], mem[16'h0203]},
        32'h1243DE5A);

    // Zero length: done with no memory access.
    issue(16'h0100, 16'h0300, 16'd0, 1'b0, 8'h00);
    chk("len0_c1", obs(), ev(0, 0, 0, 0, 1, 16'h0000, 16'h0000)); tick();
    chk("len0_c2", obs(), ev(0, 0, 0, 0, 0, 16'h0000, 16'h0000));

    // Source at 0xFFFF forces byte steps and wraps to 0x0000.
    mem[16'hFFFF] = 8'h77; mem[16'h0000] = 8'h88;
    issue(16'hFFFF, 16'h0010, 16'd2, 1'b0, 8'h00);
    chk("wrap_c1", obs(), ev(1, 0, 0, 1, 0, 16'hFFFF, 16'h0000)); tick();
    chk("wrap_c2", obs(), ev(0, 1, 1, 1, 0, 16'h0010, 16'h0077)); tick();
    chk("wrap_c3", obs(), ev(1, 0, 0, 1, 0, 16'h0000, 16'h0000)); tick();
    chk("wrap_c4", obs(), ev(0, 1, 1, 1, 0, 16'h0011, 16'h0088)); tick();
    chk("wrap_c5", obs(), ev(0, 0, 0, 0, 1, 16'h0000, 16'h0000)); tick();

    // Fill request: honoured only when the fill build option is present.
    mem[16'h0300] = 8'h11; mem[16'h0301] = 8'h22; mem[16'h0302] = 8'h33;
    issue(16'h0300, 16'h0010, 16'd3, 1'b1, 8'hA5);
`ifdef MEM_COPY_FILL_EN
    chk("fill_c1", obs(), ev(0, 1, 0, 1, 0, 16'h0010, 16'hA5A5)); tick();
    chk("fill_c2", obs(), ev(0, 1, 1, 1, 0, 16'h0012, 16'h00A5)); tick();
    chk("fill_c3", obs(), ev(0, 0, 0, 0, 1, 16'h0000, 16'h0000)); tick();
    chk("fill_mem", {mem[16'h0010], mem[16'h0011], mem[16'h0012]}, 24'hA5A5A5);
`else
    chk("nofill_c1", obs(), ev(1, 0, 0, 1, 0, 16'h0300, 16'h0000)); tick();
    chk("nofill_c2", obs(), ev(0, 1, 0, 1, 0, 16'h0010, 16'h2211)); tick();
    chk("nofill_c3", obs(), ev(1, 0, 0, 1, 0, 16'h0302, 16'h0000)); tick();
    chk("nofill_c4", obs(), ev(0, 1, 1, 1, 0, 16'h0012, 16'h0033)); tick();
    chk("nofill_c5", obs(), ev(0, 0, 0, 0, 1, 16'h0000, 16'h0000)); tick();
    chk("nofill_mem", {mem[16'h0010], mem[16'h0011], mem[16'h0012]}, 24'h112233);
`endif

    // Abort in the second RD of an 8-byte copy; a start mid-transfer is ignored.
    snap0 = mem[16'h0502]; snap1 = mem[16'h0503];
    rd_word = {mem[16'h0401], mem[16'h0400]};
    issue(16'h0400, 16'h0500, 16'd8, 1'b0, 8'h00);
    chk("abort_c1", obs(), ev(1, 0, 0, 1, 0, 16'h0400, 16'h0000)); tick();
    ifc.start = 1'b1; ifc.src_addr = 16'h0700; ifc.dst_addr = 16'h0900; ifc.length = 16'd1;
    chk("abort_c2", obs(), ev(0, 1, 0, 1, 0, 16'h0500, rd_word)); tick();
    ifc.start = 1'b0; ifc.abort = 1'b1;
    chk("abort_c3", obs(), ev(1, 0, 0, 1, 0, 16'h0402, 16'h0000)); tick();
    ifc.abort = 1'b0;
    chk("abort_c4", obs(), ev(0, 0, 0, 0, 0, 16'h0000, 16'h0000));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("abort_quiet%0d", i), obs(), ev(0, 0, 0, 0, 0, 16'h0000, 16'h0000));
    end
    chk("abort_mem", {mem[16'h0501], mem[16'h0500], mem[16'h0502], mem[16'h0503]},
        {rd_word, snap0, snap1});

    // Reset in cycle 2 of a copy, then a fresh command in cycle 3.
    rd_word = {mem[16'h0601], mem[16'h0600]};
    snap0 = mem[16'h0800];
    issue(16'h0600, 16'h0700, 16'd4, 1'b0, 8'h00);
    chk("rst_c1", obs(), ev(1, 0, 0, 1, 0, 16'h0600, 16'h0000)); tick();
    rst = 1'b1;
    chk("rst_c2", obs(), ev(0, 1, 0, 1, 0, 16'h0700, rd_word)); tick();
    rst = 1'b0;
    chk("rst_c3", obs(), ev(0, 0, 0, 0, 0, 16'h0000, 16'h0000));
    ifc.src_addr = 16'h0800; ifc.dst_addr = 16'h0900; ifc.length = 16'd1; ifc.fill = 1'b0;
    ifc.start = 1'b1; tick(); ifc.start = 1'b0;
    chk("rst_c4", obs(), ev(1, 0, 0, 1, 0, 16'h0800, 16'h0000)); tick();
    chk("rst_c5", obs(), ev(0, 1, 1, 1, 0, 16'h0900, {8'h00, snap0})); tick();
    chk("rst_c6", obs(), ev(0, 0, 0, 0, 1, 16'h0000, 16'h0000)); tick();

    // Randomized transfers against the reference model.
    for (int k = 0; k < 24; k++) begin
      s = 16'($urandom);
      if (k % 5 == 0) s = 16'hFFFF - 16'($urandom_range(0, 2));
      d = s + 16'h8000;
      if (k % 7 == 3) begin
        d = 16'hFFFF - 16'($urandom_range(0, 2));
        s = d + 16'h8000;
      end
      len = $urandom_range(0, 40);
      f = 1'($urandom_range(0, 1));
      fd = 8'($urandom);
      eff_fill = f && FillEn;

      for (int i = 0; i < len; i++) exp_bytes[i] = eff_fill ? fd : mem[16'(s + 16'(i))];
      sentinel = mem[16'(d + 16'(len))];

      rem = len; ss = s; dd = d; steps = 0;
      while (rem > 0) begin
        b = (rem >= 2 && dd != 16'hFFFF && (eff_fill || ss != 16'hFFFF)) ? 2 : 1;
        rem -= b; ss += 16'(b); dd += 16'(b); steps++;
      end
      exp_done = (len == 0) ? 1 : (eff_fill ? steps + 1 : 2 * steps + 1);

      issue(s, d, 16'(len), f, fd);
      got_done = 0; rds = 0; wrs = 0;
      for (int c = 1; c <= 200; c++) begin
        if (ifc.done === 1'b1) begin
          got_done = c;
          break;
        end
        if (ifc.memoryRead === 1'b1) rds++;
        if (ifc.memoryWrite === 1'b1) wrs++;
        tick();
      end
      chk($sformatf("rnd%0d_done_cycle", k), 64'(got_done), 64'(exp_done));
      chk($sformatf("rnd%0d_reads", k), 64'(rds), 64'(eff_fill ? 0 : steps));
      chk($sformatf("rnd%0d_writes", k), 64'(wrs), 64'(steps));
      for (int i = 0; i < len; i++)
        chk($sformatf("rnd%0d_byte%0d", k, i), 64'(mem[16'(d + 16'(i))]), 64'(exp_bytes[i]));
      chk($sformatf("rnd%0d_sentinel", k), 64'(mem[16'(d + 16'(len))]), 64'(sentinel));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
